aes_round_key_store: RTL

Iterative AES-128 key schedule with an on-chip round-key buffer. It sits directly upstream of the AES-128 round datapath. It accepts a 128-bit master key over a valid/ready handshake, expands it into all 11 round keys using one shared byte S-box, and then serves any round key by index through a registered read port. The datapath can therefore fetch round keys without on-the-fly expansion stalls.

---
 rtl/aes_round_key_store.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_key_store.sv
// -----------------------------------------------------------------------------
// aes_round_key_store
//
// Iterative AES-128 key schedule with an on-chip round-key buffer.
// A 128-bit master key is accepted over a valid/ready handshake and expanded
// into all 11 round keys using one shared byte S-box (5 cycles per round,
// 50 cycles total). Any round key can then be read by index through a
// registered read port.
//
// Handshake: a key transfer happens on a rising clk edge where key_valid and
// key_ready are both high. key_ready is high only while idle. key_valid seen
// while key_ready is low is ignored; key_in is not sampled and nothing queues.
//
// Ports:
//   clk          in   1    clock
//   rst_n        in   1    asynchronous active-low reset
//   key_in       in   128  master key, [127:120] = key byte 0, w0 = [127:96]
//   key_valid    in   1    key_in valid this cycle
//   key_ready    out  1    block can accept a key (idle only)
//   keys_valid   out  1    all 11 round keys stored for the last accepted key
//   rd_round     in   4    round index to read, 0..10 (11..15 read as zero)
//   rd_key       out  128  registered round key, w(4r) in [127:96]
//   dbg_state_o  out  2    FSM state for observation: 0 idle, 1 sub, 2 mix
// -----------------------------------------------------------------------------
module aes_round_key_store (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2
  } state_e;

  // AES forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for expansion round r (1..10); zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e         state_q;
  logic [1:0]     c_q;          // byte counter within SUB
  logic [3:0]     r_q;          // round currently being expanded
  logic [31:0]    temp_q;       // SubWord(RotWord(w4r-1)), filled one byte per SUB cycle
  logic [31:0]    temp_d;
  logic [127:0]   rk_q [0:10];
  logic           keys_valid_q;
  logic           key_ready_q;
  logic [127:0]   rd_key_q;

  // ---------------------------------------------------------------------------
  // Expansion datapath
  // ---------------------------------------------------------------------------
  logic [3:0]     prev_idx;
  logic [127:0]   prev_rk;      // rk[r-1], source of w4r-4 .. w4r-1
  logic [31:0]    rot_word;
  logic [7:0]     sbox_in;
  logic [7:0]     sbox_out;
  logic [31:0]    t_word;
  logic [31:0]    w0_new;
  logic [31:0]    w1_new;
  logic [31:0]    w2_new;
  logic [31:0]    w3_new;
  logic [127:0]   mix_key;

  assign prev_idx = r_q - 4'd1;

  // Explicit select keeps every index inside 0..10 even when r_q is 0.
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < 11; i++) begin
      if (prev_idx == 4'(i)) prev_rk = rk_q[i];
    end
  end

  // RotWord of w4r-1: {b1,b2,b3,b0}, with b0 the most significant byte.
  assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

  // Byte c of the rotated word feeds the single shared S-box.
  always_comb begin
    sbox_in = 8'h00;
    case (c_q)
      2'd0: sbox_in = rot_word[31:24];
      2'd1: sbox_in = rot_word[23:16];
      2'd2: sbox_in = rot_word[15:8];
      2'd3: sbox_in = rot_word[7:0];
      default: sbox_in = 8'h00;
    endcase
  end

  assign sbox_out = SBOX[sbox_in];

  always_comb begin
    temp_d = temp_q;
    case (c_q)
      2'd0: temp_d[31:24] = sbox_out;
      2'd1: temp_d[23:16] = sbox_out;
      2'd2: temp_d[15:8]  = sbox_out;
      2'd3: temp_d[7:0]   = sbox_out;
      default: temp_d = temp_q;
    endcase
  end

  // The four new words chain through each other within one MIX cycle.
  assign t_word  = temp_q ^ {rcon(r_q), 24'h000000};
  assign w0_new  = prev_rk[127:96] ^ t_word;
  assign w1_new  = prev_rk[95:64]  ^ w0_new;
  assign w2_new  = prev_rk[63:32]  ^ w1_new;
  assign w3_new  = prev_rk[31:0]   ^ w2_new;
  assign mix_key = {w0_new, w1_new, w2_new, w3_new};

  // ---------------------------------------------------------------------------
  // Read port select: indexes above 10 read as zero.
  // ---------------------------------------------------------------------------
  logic [127:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < 11; i++) begin
      if (rd_round == 4'(i)) rd_sel = rk_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, key buffer and read register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      c_q          <= 2'd0;
      r_q          <= 4'd0;
      temp_q       <= 32'h0;
      keys_valid_q <= 1'b0;
      key_ready_q  <= 1'b1;
      rd_key_q     <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      // Reads are served in every state; during expansion they return the
      // partially updated buffer, so consumers gate on keys_valid.
      rd_key_q <= rd_sel;

      case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            rk_q[0]      <= key_in;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b0;
            r_q          <= 4'd1;
            c_q          <= 2'd0;
            state_q      <= ST_SUB;
          end
        end

        ST_SUB: begin
          temp_q <= temp_d;
          c_q    <= c_q + 2'd1;   // wraps back to 0 after byte 3
          if (c_q == 2'd3) state_q <= ST_MIX;
        end

        ST_MIX: begin
          for (int i = 1; i < 11; i++) begin
            if (r_q == 4'(i)) rk_q[i] <= mix_key;
          end
          if (r_q == 4'd10) begin
            // keys_valid and key_ready rise together on the final write.
            keys_valid_q <= 1'b1;
            key_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            r_q     <= r_q + 4'd1;
            state_q <= ST_SUB;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          key_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready   = key_ready_q;
  assign keys_valid  = keys_valid_q;
  assign rd_key      = rd_key_q;
  assign dbg_state_o = state_q;

endmodule
